// File: rtl/imem_fetch_unit_if.sv
// rtl/imem_fetch_unit_if.sv - request, memory and output signals of the fetch front end
interface imem_fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [0:79]       instruct;
  logic [63:0]       out_pc;
  logic [3:0]        out_len;
  logic              out_mem_err;

  // fetch unit side
  modport slave (
    input  flush, req_valid, req_pc, mem_rdata, out_ready,
    output req_ready, mem_addr, mem_rd_en, out_valid, instruct, out_pc, out_len, out_mem_err
  );

  // environment side: requester, instruction memory and fetch stage
  modport master (
    output flush, req_valid, req_pc, mem_rdata, out_ready,
    input  req_ready, mem_addr, mem_rd_en, out_valid, instruct, out_pc, out_len, out_mem_err
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// rtl/imem_fetch_unit.sv - byte-serial instruction fetch that packs bytes into the 80-bit instruct word
module imem_fetch_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [3:0]  r_issue_cnt;
  logic [3:0]  r_cap_cnt;
  logic [3:0]  r_len;
  logic [3:0]  r_out_len;
  logic [0:79] r_instruct;
  logic        r_out_valid;
  logic        r_out_mem_err;

  logic [63:0] w_sum;
  logic [63:0] w_wrap;
  logic [3:0]  w_len0;
  logic        w_span_err;
  logic [6:0]  w_off;

  // instruction length in bytes from the icode nibble; C-F fall through as 1 byte
  function automatic logic [3:0] len_of(input logic [3:0] icode);
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
      4'h3, 4'h4, 4'h5:       len_of = 4'd10;
      4'h7, 4'h8:             len_of = 4'd9;
      default:                len_of = 4'd1;
    endcase
  endfunction

  assign w_len0     = len_of(bus.mem_rdata[7:4]);
  assign w_span_err = (r_pc + 64'(w_len0)) > 64'(MEM_BYTES);

  // pc is in range while reading, so one conditional subtract is enough to wrap
  assign w_sum  = r_pc + 64'(r_issue_cnt);
  assign w_wrap = (w_sum >= 64'(MEM_BYTES)) ? (w_sum - 64'(MEM_BYTES)) : w_sum;

  // bit offset in instruct for captured byte k>0; constants are little-endian in memory
  always_comb begin
    w_off = 7'd8;
    if (r_len == 4'd10 && r_cap_cnt != 4'd1) begin
      w_off = 7'd88 - {r_cap_cnt, 3'b000};
    end else if (r_len == 4'd9) begin
      w_off = 7'd72 - {r_cap_cnt, 3'b000};
    end
  end

  assign bus.req_ready   = (r_state == IDLE) && !bus.flush;
  assign bus.mem_rd_en   = (r_state == READ);
  assign bus.mem_addr    = (r_state == READ) ? ADDR_W'(w_wrap) : '0;
  assign bus.out_valid   = r_out_valid;
  assign bus.instruct    = r_instruct;
  assign bus.out_pc      = r_pc;
  assign bus.out_len     = r_out_len;
  assign bus.out_mem_err = r_out_mem_err;

  // fetch sequencer: accept, issue/capture bytes, then hold the result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_issue_cnt   <= '0;
      r_cap_cnt     <= '0;
      r_len         <= '0;
      r_out_len     <= '0;
      r_instruct    <= '0;
      r_out_valid   <= 1'b0;
      r_out_mem_err <= 1'b0;
    end else if (bus.flush) begin
      r_state       <= IDLE;
      r_out_valid   <= 1'b0;
      r_out_mem_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_pc        <= bus.req_pc;
            r_instruct  <= '0;
            r_out_len   <= '0;
            r_issue_cnt <= '0;
            r_cap_cnt   <= '0;
            r_len       <= '0;
            if (bus.req_pc > 64'(MEM_BYTES - 1)) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_out_mem_err <= 1'b1;
            end else begin
              r_state       <= READ;
              r_out_mem_err <= 1'b0;
            end
          end
        end
        READ: begin
          r_issue_cnt <= r_issue_cnt + 4'd1;
          if (r_issue_cnt != 4'd0) begin
            r_cap_cnt <= r_cap_cnt + 4'd1;
            if (r_cap_cnt == 4'd0) begin
              r_len <= w_len0;
              if (w_span_err) begin
                r_state       <= DONE;
                r_out_valid   <= 1'b1;
                r_out_mem_err <= 1'b1;
                r_out_len     <= '0;
              end else begin
                r_instruct[0:7] <= bus.mem_rdata;
                if (w_len0 == 4'd1) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_out_len   <= 4'd1;
                end
              end
            end else begin
              r_instruct[w_off +: 8] <= bus.mem_rdata;
              if (r_cap_cnt == r_len - 4'd1) begin
                r_state     <= DONE;
                r_out_valid <= 1'b1;
                r_out_len   <= r_len;
              end
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb/tb_imem_fetch_unit.sv - directed and randomized checks of imem_fetch_unit against a byte-level model
module tb_imem_fetch_unit;
  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  imem_fetch_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:MEM_BYTES-1];

  // one-cycle synchronous byte memory
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [79:0] ins;
    int          len;
    bit          err;
    int          lat;
  } exp_t;

  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected result of fetching at pc given the current memory image
  function automatic exp_t model(input logic [63:0] pc);
    exp_t        e;
    logic [63:0] c;
    int          p;
    int          n;
    e.ins = '0;
    e.len = 0;
    e.err = 1'b0;
    e.lat = 0;
    if (pc > 64'(MEM_BYTES - 1)) begin
      e.err = 1'b1;
      return e;
    end
    p = int'(pc);
    n = len_tab[mem[p][7:4]];
    if (p + n > MEM_BYTES) begin
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    e.len = n;
    e.lat = n + 1;
    c = '0;
    if (n == 10) begin
      for (int i = 9; i >= 2; i--) c = (c << 8) | 64'(mem[p + i]);
      e.ins = {mem[p], mem[p + 1], c};
    end else if (n == 9) begin
      for (int i = 8; i >= 1; i--) c = (c << 8) | 64'(mem[p + i]);
      e.ins = {mem[p], c, 8'h00};
    end else if (n == 2) begin
      e.ins = {mem[p], mem[p + 1], 64'h0};
    end else begin
      e.ins = {mem[p], 72'h0};
    end
    return e;
  endfunction

  task automatic fetch(input logic [63:0] pc, input int hold);
    exp_t e;
    int   k;
    bit   rd_seen;
    e = model(pc);
    @(negedge clk);
    chk("req_ready_idle", 80'(bus.req_ready), 80'(1));
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    k       = 0;
    rd_seen = 1'b0;
    while (!bus.out_valid && k < 40) begin
      if (bus.mem_rd_en) begin
        rd_seen = 1'b1;
        chk("mem_addr", 80'(bus.mem_addr), 80'((pc + 64'(k)) % 64'(MEM_BYTES)));
      end
      @(negedge clk);
      k++;
    end
    rd_seen = rd_seen | bus.mem_rd_en;
    chk("latency", 80'(k), 80'(e.lat));
    chk("out_mem_err", 80'(bus.out_mem_err), 80'(e.err));
    chk("out_len", 80'(bus.out_len), 80'(e.len));
    chk("instruct", bus.instruct, e.ins);
    chk("out_pc", 80'(bus.out_pc), 80'(pc));
    if (pc > 64'(MEM_BYTES - 1)) chk("no_reads", 80'(rd_seen), 80'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 80'(bus.out_valid), 80'(1));
      chk("hold_instruct", bus.instruct, e.ins);
      chk("hold_len", 80'(bus.out_len), 80'(e.len));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", 80'(bus.out_valid), 80'(0));
    chk("req_ready_after", 80'(bus.req_ready), 80'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 80'(bus.out_valid), 80'(0));
    chk({tag, "_err"}, 80'(bus.out_mem_err), 80'(0));
    chk({tag, "_rd_en"}, 80'(bus.mem_rd_en), 80'(0));
    chk({tag, "_instruct"}, bus.instruct, 80'(0));
    chk({tag, "_pc"}, 80'(bus.out_pc), 80'(0));
    chk({tag, "_len"}, 80'(bus.out_len), 80'(0));
    chk({tag, "_addr"}, 80'(bus.mem_addr), 80'(0));
  endtask

  // start an irmovq at 0x10, abort it in its 4th cycle by flush or reset
  task automatic abort_fetch(input bit use_rst);
    int ov_seen;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_pc    = 64'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst_n = 1'b0;
    else         bus.flush = 1'b1;
    @(negedge clk);
    if (use_rst) begin
      check_reset_outputs("rst_abort");
      rst_n = 1'b1;
    end else begin
      chk("flush_valid", 80'(bus.out_valid), 80'(0));
      chk("flush_rd_en", 80'(bus.mem_rd_en), 80'(0));
      chk("flush_ready_low", 80'(bus.req_ready), 80'(0));
      bus.flush = 1'b0;
    end
    #1;
    chk("abort_idle_ready", 80'(bus.req_ready), 80'(1));
    ov_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.mem_rd_en) ov_seen++;
    end
    chk("abort_quiet", 80'(ov_seen), 80'(0));
    fetch(64'h10, 0);
  endtask

  initial begin
    logic [63:0] pc;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 80'(bus.req_ready), 80'(1));

    // halt
    mem[0] = 8'h00;
    fetch(64'h0, 0);

    // irmovq
    mem[16] = 8'h30; mem[17] = 8'hF3;
    for (int i = 0; i < 8; i++) mem[18 + i] = 8'(8 - i);
    fetch(64'h10, 0);
    chk("irmovq_const", bus.instruct, 80'h30F3_0102030405060708);

    // jmp
    mem[32] = 8'h70; mem[33] = 8'h00; mem[34] = 8'h01;
    for (int i = 35; i < 41; i++) mem[i] = 8'h00;
    fetch(64'h20, 0);
    chk("jmp_const", bus.instruct, 80'h70_0000000000000100_00);

    // span error and pc out of range
    mem[1020] = 8'h30; mem[1021] = 8'hF3;
    fetch(64'd1020, 0);
    fetch(64'd2000, 0);

    // backpressure on addq
    mem[64] = 8'h60; mem[65] = 8'h23;
    fetch(64'h40, 5);

    // last byte of memory: the second issue wraps to address 0 and is discarded
    mem[1023] = 8'h10;
    fetch(64'd1023, 0);

    // flush and reset aborts
    abort_fetch(1'b0);
    abort_fetch(1'b1);

    // flush in the same cycle as a request: not accepted
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pc    = 64'h20;
    #1;
    chk("flush_blocks_ready", 80'(bus.req_ready), 80'(0));
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    chk("flush_req_no_read", 80'(bus.mem_rd_en), 80'(0));
    chk("flush_req_no_valid", 80'(bus.out_valid), 80'(0));

    // randomized fetches
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       pc = 64'(MEM_BYTES) + 64'($urandom_range(0, 5000));
        1:       pc = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        2, 3:    pc = 64'(MEM_BYTES - 10 + $urandom_range(0, 9));
        default: pc = 64'($urandom_range(0, MEM_BYTES - 1));
      endcase
      for (int i = 0; i < 10; i++) begin
        if (pc + 64'(i) < 64'(MEM_BYTES)) mem[int'(pc) + i] = 8'($urandom);
      end
      fetch(pc, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
